mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end for the data memory: sits between the CPU's memory stage and a single-port, 32-bit-wide block RAM.
- The RAM has one-cycle registered read latency and full-word writes only.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM word accesses.
- Performs byte/halfword extraction with sign/zero extension on loads, and read-modify-write for sub-word stores.
- Flags misaligned, out-of-range and illegal accesses.

Parameters:
- L, 256, depth of the attached RAM in 32-bit words; word address width AW = $clog2(L).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  CPU request present
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 (size/sign)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-aligned
- resp_valid  output  1  one-cycle pulse: response for the accepted request
- resp_rdata  output  32  extended load data (0 for stores/errors)
- resp_err  output  1  request was misaligned, out of range or illegal; RAM untouched
- ram_addr  output  AW  word address to RAM
- ram_wr_ena  output  1  RAM write enable
- ram_wr_data  output  32  RAM write data
- ram_rd_data  input  32  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- Reset (async, rst_n=0): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0; latched request regs=0; ram_wr_ena=0.
- Reset mid-operation: abandons the operation with no response and no further RAM write. A write already committed stays.
- States:
  - IDLE: req_ready=1.
  - RD: issue read.
  - RD2: RAM data valid.
  - WR: issue write.
- req_ready=1 only in IDLE. Acceptance = req_valid & req_ready at a clock edge; it latches write, funct3, addr and wdata.
- Error check at acceptance:
  - Illegal funct3: loads 3/6/7, stores >2.
  - Halfword with addr[0]!=0.
  - Word with addr[1:0]!=0.
  - addr[31:2] >= L.
  - On error: stay IDLE, resp_valid=1 and resp_err=1 next cycle, resp_rdata=0, no RAM access.
- Legal load: IDLE->RD->RD2->IDLE. At the RD2 exit edge: resp_rdata <= extracted value, resp_valid <= 1.
  - Response is visible 2 cycles after the accept edge.
- SW: IDLE->WR->IDLE. The RAM writes at the WR exit edge; resp_valid is asserted 1 cycle after accept.
- SB/SH: IDLE->RD->RD2->WR->IDLE.
  - In RD2, merge the new byte/half into ram_rd_data at lane addr[1:0] and register the result as ram_wr_data.
  - WR writes it; resp_valid is asserted 3 cycles after accept.
- RAM outputs are Moore-style from state and latched regs:
  - ram_addr = latched addr[AW+1:2] in RD/RD2/WR; 0 in IDLE.
  - ram_wr_ena=1 only in WR.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store data: uses req_wdata[7:0] (SB) or [15:0] (SH); upper bits ignored.
- resp_valid is a single-cycle pulse. The unit is back in IDLE during the pulse cycle and may accept the next request in that same cycle (back-to-back).
- resp_rdata/resp_err hold their value until the next response.
- Store responses: resp_rdata=0, resp_err=0.

Decomposition:
- Package mem_pkg:
  - Enum mem_funct3_t (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5).
  - Enum mau_state_t (IDLE, RD, RD2, WR).
  - Function is_aligned(funct3, addr[1:0]).
- One combinational sub-module load_store_align:
  - Inputs: word, addr[1:0], funct3, wdata.
  - Outputs: extended load data and merged store word.
  - Keeps the lane logic out of the FSM.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF; then LW 0x10 -> ram_wr_ena in the cycle after accept with ram_addr=4; load resp_rdata=0xDEADBEEF, resp_err=0, 2 cycles after accept.
- With word 4 = 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11, wdata 0x12345655 on word 0xDEADBEEF -> RD,RD2,WR sequence; RAM word becomes 0xDEAD55EF; resp_valid 3 cycles after accept.
- LW 0x12, SH 0x13, LB addr 0x400 (L=256), funct3=3 load -> each gives resp_err=1 the next cycle, no ram_wr_ena, RAM contents unchanged.
- Back-to-back: req_valid held high with SW 0x0 then LW 0x0 -> second request accepted in the first's resp_valid cycle; load returns the new data.
- Drop rst_n during the RD2 of an SH -> outputs zero immediately; no WR cycle; RAM word unchanged; unit accepts a new request after release.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and helpers for the load/store front end:
//                RV32I load/store size encodings, controller states and
//                access legality checks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // RV32I load/store funct3 encodings (size and signedness)
    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_BU = 3'd4,
        F3_HU = 3'd5
    } mem_funct3_t;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RD2  = 2'd2,
        WR   = 2'd3
    } mau_state_t;

    // Halfwords need an even address, words a multiple of four; bytes never fault.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3[1:0])
            2'b01:   ok = ~addr_lo[0];
            2'b10:   ok = (addr_lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Stores only have signed encodings B/H/W; loads also have BU/HU.
    function automatic logic is_legal_funct3(input logic write, input logic [2:0] funct3);
        logic ok;
        if (write) begin
            ok = (funct3 <= 3'd2);
        end else begin
            ok = (funct3 != 3'd3) && (funct3 < 3'd6);
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_align
//  Description : Byte-lane logic: extracts and extends load data from a RAM
//                word, and merges sub-word store data into a RAM word.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane, then sign/zero extend according to funct3
    always_comb begin
        w_byte      = i_word[7:0];
        w_half      = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Overwrite only the addressed byte/half lane of the current RAM word
    always_comb begin
        o_store_word = i_word;
        case (i_funct3[1:0])
            2'b00: begin
                case (i_addr_lo)
                    2'd0:    o_store_word[7:0]   = i_wdata[7:0];
                    2'd1:    o_store_word[15:8]  = i_wdata[7:0];
                    2'd2:    o_store_word[23:16] = i_wdata[7:0];
                    default: o_store_word[31:24] = i_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (i_addr_lo[1]) begin
                    o_store_word[31:16] = i_wdata;
                end else begin
                    o_store_word[15:0] = i_wdata;
                end
            end
            default: o_store_word = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : RV32I load/store front end for a single-port 32-bit block
//                RAM with one-cycle read latency. Sub-word stores are done
//                as read-modify-write; bad accesses are rejected up front.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int L  = 256,
    localparam int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wr_ena,
    output logic [31:0]   ram_wr_data,
    input  logic [31:0]   ram_rd_data
);

    mau_state_t   r_state;
    mau_state_t   w_next_state;

    logic         r_write;
    logic [2:0]   r_funct3;
    logic [AW+1:0] r_addr;
    logic [15:0]  r_wdata;
    logic [31:0]  r_wr_data;

    logic         r_resp_valid;
    logic [31:0]  r_resp_rdata;
    logic         r_resp_err;

    logic         w_accept;
    logic         w_err;
    logic [31:0]  w_load_data;
    logic [31:0]  w_store_word;

    assign w_accept = req_valid & req_ready;
    assign w_err    = ~is_legal_funct3(req_write, req_funct3)
                    | ~is_aligned(req_funct3, req_addr[1:0])
                    | (req_addr[31:2] >= 30'(L));

    load_store_align u_align (
        .i_word       (ram_rd_data),
        .i_addr_lo    (r_addr[1:0]),
        .i_funct3     (r_funct3),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and Moore outputs; full-word stores skip the read phase
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        ram_wr_ena   = 1'b0;
        ram_addr     = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept && !w_err) begin
                    w_next_state = (req_write && req_funct3 == F3_W) ? WR : RD;
                end
            end
            RD: begin
                ram_addr     = r_addr[AW+1:2];
                w_next_state = RD2;
            end
            RD2: begin
                ram_addr     = r_addr[AW+1:2];
                w_next_state = r_write ? WR : IDLE;
            end
            default: begin
                ram_addr     = r_addr[AW+1:2];
                ram_wr_ena   = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the request on acceptance; build the RAM write word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write   <= 1'b0;
            r_funct3  <= 3'd0;
            r_addr    <= '0;
            r_wdata   <= 16'd0;
            r_wr_data <= 32'd0;
        end else if (w_accept) begin
            r_write   <= req_write;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr[AW+1:0];
            r_wdata   <= req_wdata[15:0];
            r_wr_data <= req_wdata;
        end else if (r_state == RD2 && r_write) begin
            r_wr_data <= w_store_word;
        end
    end

    // Response pulse; data and error hold until the next response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_accept && w_err) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= 32'd0;
                r_resp_err   <= 1'b1;
            end else if (r_state == RD2 && !r_write) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= w_load_data;
                r_resp_err   <= 1'b0;
            end else if (r_state == WR) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= 32'd0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign ram_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed self-checking bench for mem_access_unit with a
//                behavioural one-cycle-latency RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int L  = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_wr_ena;
    logic [31:0]   ram_wr_data;
    logic [31:0]   ram_rd_data;

    logic [31:0]   mem [0:L-1];
    int            wr_count = 0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.L(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .ram_addr    (ram_addr),
        .ram_wr_ena  (ram_wr_ena),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    // Block RAM: registered read, full-word write
    always @(posedge clk) begin
        if (ram_wr_ena) begin
            mem[ram_addr] <= ram_wr_data;
            wr_count      <= wr_count + 1;
        end
        ram_rd_data <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present one request for one edge; returns just after the accept edge
    task automatic do_accept(input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // Edges elapsed until resp_valid is seen (-1 if never within budget)
    task automatic wait_resp(output int lat);
        bit found;
        found = 1'b0;
        lat   = -1;
        for (int k = 0; k < 8; k++) begin
            if (!found && resp_valid) begin
                lat   = k;
                found = 1'b1;
            end
            if (!found) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, resp_err, ram_wr_ena, req_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_ctrl got={v,e,we,rdy}=%b exp=0001",
                     {resp_valid, resp_err, ram_wr_ena, req_ready});
        end
        checks++;
        if ({resp_rdata, ram_wr_data, ram_addr} !== 72'd0) begin
            failures++;
            $display("FAIL reset_data rdata=%h wr_data=%h addr=%h exp all 0",
                     resp_rdata, ram_wr_data, ram_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sw_lw();
        int lat;
        do_accept(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({ram_wr_ena, req_ready, ram_addr, ram_wr_data} !== {1'b1, 1'b0, 8'd4, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL sw_ram we=%b rdy=%b addr=%h data=%h exp 1 0 04 deadbeef",
                     ram_wr_ena, req_ready, ram_addr, ram_wr_data);
        end
        wait_resp(lat);
        checks++;
        if ({lat, resp_err, resp_rdata} !== {32'd1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL sw_resp lat=%0d err=%b rdata=%h exp 1 0 0", lat, resp_err, resp_rdata);
        end
        do_accept(1'b0, 3'd2, 32'h10, 32'h0);
        wait_resp(lat);
        checks++;
        if ({lat, resp_err, resp_rdata} !== {32'd2, 1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL lw_resp lat=%0d err=%b rdata=%h exp 2 0 deadbeef", lat, resp_err, resp_rdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, resp_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL lw_pulse_hold v=%b rdata=%h exp 0 deadbeef", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] exp_d [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_accept(1'b0, f3[i], ad[i], 32'h0);
            wait_resp(lat);
            checks++;
            if ({lat, resp_err, resp_rdata} !== {32'd2, 1'b0, exp_d[i]}) begin
                failures++;
                $display("FAIL load_ext[%0d] lat=%0d err=%b rdata=%h exp 2 0 %h",
                         i, lat, resp_err, resp_rdata, exp_d[i]);
            end
        end
    endtask

    task automatic test_sb();
        int lat;
        int w0;
        w0 = wr_count;
        do_accept(1'b1, 3'd0, 32'h11, 32'h12345655);
        checks++;
        if ({ram_wr_ena, ram_addr} !== {1'b0, 8'd4}) begin
            failures++;
            $display("FAIL sb_rd we=%b addr=%h exp 0 04", ram_wr_ena, ram_addr);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if ({ram_wr_ena, ram_addr, ram_wr_data} !== {1'b1, 8'd4, 32'hDEAD55EF}) begin
            failures++;
            $display("FAIL sb_wr we=%b addr=%h data=%h exp 1 04 dead55ef",
                     ram_wr_ena, ram_addr, ram_wr_data);
        end
        wait_resp(lat);
        checks++;
        if ({lat + 2, resp_err, resp_rdata, mem[4], wr_count} !==
            {32'd3, 1'b0, 32'd0, 32'hDEAD55EF, w0 + 1}) begin
            failures++;
            $display("FAIL sb_resp lat=%0d err=%b rdata=%h mem4=%h writes=%0d exp 3 0 0 dead55ef %0d",
                     lat + 2, resp_err, resp_rdata, mem[4], wr_count - w0, 1);
        end
        do_accept(1'b0, 3'd2, 32'h10, 32'h0);
        wait_resp(lat);
        checks++;
        if (resp_rdata !== 32'hDEAD55EF) begin
            failures++;
            $display("FAIL sb_readback rdata=%h exp dead55ef", resp_rdata);
        end
    endtask

    task automatic test_errors();
        logic        wr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3 [4] = '{3'd2, 3'd1, 3'd0, 3'd3};
        logic [31:0] ad [4] = '{32'h12, 32'h13, 32'h400, 32'h10};
        int lat;
        int w0;
        for (int i = 0; i < 4; i++) begin
            w0 = wr_count;
            do_accept(wr[i], f3[i], ad[i], 32'hFFFFFFFF);
            wait_resp(lat);
            checks++;
            if ({lat, resp_err, resp_rdata, ram_wr_ena, req_ready} !==
                {32'd0, 1'b1, 32'd0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL err[%0d] lat=%0d err=%b rdata=%h we=%b rdy=%b exp 0 1 0 0 1",
                         i, lat, resp_err, resp_rdata, ram_wr_ena, req_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({wr_count, mem[4], resp_valid} !== {w0, 32'hDEAD55EF, 1'b0}) begin
                failures++;
                $display("FAIL err_ram[%0d] writes=%0d mem4=%h v=%b exp 0 dead55ef 0",
                         i, wr_count - w0, mem[4], resp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h0;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        checks++;
        if (ram_wr_ena !== 1'b1) begin
            failures++;
            $display("FAIL b2b_sw_we got=%b exp 1", ram_wr_ena);
        end
        @(negedge clk);
        req_write  = 1'b0;
        req_wdata  = 32'h0;
        @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, req_ready, resp_err} !== 3'b110) begin
            failures++;
            $display("FAIL b2b_pulse v=%b rdy=%b err=%b exp 1 1 0", resp_valid, req_ready, resp_err);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if ({req_ready, ram_wr_ena} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_accept rdy=%b we=%b exp 0 0", req_ready, ram_wr_ena);
        end
        wait_resp(lat);
        checks++;
        if ({lat, resp_err, resp_rdata} !== {32'd2, 1'b0, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL b2b_lw lat=%0d err=%b rdata=%h exp 2 0 cafef00d", lat, resp_err, resp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int w0;
        do_accept(1'b1, 3'd2, 32'h20, 32'h11223344);
        wait_resp(lat);
        do_accept(1'b1, 3'd1, 32'h22, 32'h0000AAAA);
        @(posedge clk);
        #1;
        w0 = wr_count;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({resp_valid, resp_err, ram_wr_ena, req_ready, resp_rdata, ram_addr, ram_wr_data} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 8'd0, 32'd0}) begin
            failures++;
            $display("FAIL midrst_out v=%b e=%b we=%b rdy=%b rdata=%h addr=%h wd=%h exp 0 0 0 1 0 0 0",
                     resp_valid, resp_err, ram_wr_ena, req_ready, resp_rdata, ram_addr, ram_wr_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({wr_count, mem[8]} !== {w0, 32'h11223344}) begin
            failures++;
            $display("FAIL midrst_ram writes=%0d mem8=%h exp 0 11223344", wr_count - w0, mem[8]);
        end
        do_accept(1'b0, 3'd2, 32'h20, 32'h0);
        wait_resp(lat);
        checks++;
        if ({lat, resp_err, resp_rdata} !== {32'd2, 1'b0, 32'h11223344}) begin
            failures++;
            $display("FAIL midrst_lw lat=%0d err=%b rdata=%h exp 2 0 11223344", lat, resp_err, resp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_load_ext();
        test_sb();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
